sd_block_reader: RTL and testbench
==================================

# sd_block_reader

Single-block read controller for the SD card SPI path. It sits between a block-level requester and the SPI command engine (`sd_spi_output_init`). Once card initialisation reports ready, it sequences one CMD17 (READ_SINGLE_BLOCK) per request, checks the R1 response and the start token, and streams the 512 data bytes out with valid/last strobes. Ownership of the SPI engine is granted by the top level muxing on `sd_ready`: this block drives the engine only while `sd_ready`=1.

## Interface
- `TOKEN_WAIT`, 256: number of response bytes after R1 in which the 0xFE start token must appear; legal range 1..508.
- `clk` input 1: SD clock domain (`sd_clk_gen`); every register in the block is clocked on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sd_ready` input 1: card initialisation is complete and this block owns the SPI engine.
- `card_sdhc` input 1: 1 = block addressing, 0 = byte addressing.
- `rd_req` input 1: read request, sampled only in IDLE.
- `rd_addr` input 32: block number, sampled together with `rd_req`.
- `rd_busy` output 1: a request is in progress.
- `rd_done` output 1: one-cycle completion pulse.
- `rd_err` output 3: error code, valid from the `rd_done` pulse until the next acceptance.
- `data_out` output 8: data byte.
- `data_valid` output 1: one-cycle strobe for `data_out`.
- `data_last` output 1: asserted with `data_valid` on byte 511.
- `crc_out` output 16: received data CRC, MSB first; captured but not checked.
- `spi_cmd_data` output 48: command frame.
- `spi_cmd` output 1: one-cycle command start.
- `spi_bytes_expected` output 10: number of response bytes to return.
- `spi_busy` input 1: engine busy.
- `spi_error` input 1: engine timeout or fault, level signal.
- `spi_response` input 8: response byte.
- `spi_avail` input 1: one-cycle strobe for `spi_response`.

## Operation
- Engine contract:
  - `spi_cmd` is issued only while `spi_busy`=0.
  - The engine raises `spi_busy` the cycle after `spi_cmd`.
  - It skips leading 0xFF bytes, then returns exactly `spi_bytes_expected` bytes, the first being R1.
  - It drops `spi_busy` after the last byte.
- Frame layout:
  - byte0 = 0x51.
  - bytes1-4 = arg, MSB first. arg = `rd_addr` when `card_sdhc`=1, else {`rd_addr`[22:0], 9'b0}.
  - byte5 = 0xFF.
  - The frame is held stable from ISSUE until DONE.
- `spi_bytes_expected` = 1 + `TOKEN_WAIT` + 514, constant (771 at default).
- States:
  - IDLE: if `rd_req`, latch the address and sdhc flag, set `rd_busy`. If `sd_ready`=1 go to ISSUE; if 0 go to DONE with err 6.
  - ISSUE: wait for `spi_busy`=0, then pulse `spi_cmd` for one cycle and go to R1.
  - R1: on `spi_avail`, a byte of 0x00 goes to TOKEN; any other value latches err 1 and goes to DRAIN.
  - TOKEN: on each `spi_avail`:
    - 0xFE goes to DATA.
    - 0xFF increments the wait count; when the count reaches `TOKEN_WAIT`, latch err 2 and go to DRAIN.
    - A byte with upper nibble 0 (data error token) latches err 3 and goes to DRAIN.
    - Any other byte counts as 0xFF.
  - DATA: on each `spi_avail`, register the byte to `data_out` and pulse `data_valid` the next cycle. The 10-bit counter runs 0..511; at 511 assert `data_last` and go to CRC.
  - CRC: two bytes into `crc_out`[15:8], then `crc_out`[7:0]; then go to DRAIN.
  - DRAIN: discard bytes; when `spi_busy`=0 go to DONE.
  - DONE: pulse `rd_done`, clear `rd_busy`, go to IDLE.
- Error priority:
  - `spi_error`=1 in any of R1, TOKEN, DATA, CRC or DRAIN latches err 4, unless an error is already latched, and goes to DRAIN.
  - `spi_busy`=0 in R1, TOKEN, DATA or CRC with no error latched latches err 5 (premature end) and goes to DONE.
  - The first latched error wins.
- Error codes: 0 ok, 1 R1 non-zero, 2 token timeout, 3 data error token, 4 engine error, 5 premature end, 6 not ready.
- After any error, no further `data_valid` is issued for that request.
- `rd_req` outside IDLE is ignored.

## Timing
- Reset values:
  - `rd_busy`, `rd_done`, `data_valid`, `data_last`, `spi_cmd` = 0.
  - `rd_err`, `data_out`, `crc_out` = 0.
  - `spi_cmd_data` = 48'hFFFF_FFFF_FFFF.
  - `spi_bytes_expected` = constant.
  - State = IDLE.
- Reset mid-operation returns to IDLE on the next edge with no `rd_done`. The engine shares the reset.
- Request accepted at edge t: `rd_busy`=1 from t+1; `spi_cmd` at t+1 if the engine is idle.
- Not-ready request accepted at t: `rd_done` with err 6 at t+1.
- Data latency: `data_valid` is 1 cycle after the corresponding `spi_avail`.
- `rd_done` is registered; it follows the DRAIN exit (busy low) by 1 cycle.
- `rd_busy` falls in the same cycle `rd_done` rises.
- Back-to-back: a new `rd_req` may be accepted in the cycle after `rd_done`.

## Test plan
- SDHC read, `rd_addr`=0x10:
  - Stimulus: engine returns R1=0x00, three 0xFF, 0xFE, bytes i&0xFF for i=0..511, CRC 0xABCD.
  - Required: `spi_cmd_data`=0x51_0000_0010_FF; 512 `data_valid` with matching data; `data_last` on byte 511; `crc_out`=0xABCD; `rd_err`=0.
- SDSC addressing: `rd_addr`=0x3 with `card_sdhc`=0 -> frame arg = 0x0000_0600.
- R1=0x05 -> no `data_valid`; `rd_done` with `rd_err`=1 after the engine drops busy.
- Token failures:
  - 256 0xFF bytes after R1 -> `rd_err`=2.
  - Separate run: token 0x08 -> `rd_err`=3.
- `spi_busy` falls at data byte 100 -> `rd_err`=5, exactly 100 `data_valid` pulses.
- Unready and reset cases:
  - `rd_req` with `sd_ready`=0 -> `rd_done` with err 6 one cycle later and no `spi_cmd`.
  - `rst` asserted during DATA -> all outputs at reset values next cycle, no `rd_done`.

Source files
------------

// File: rtl/sd_block_reader.sv
// sd_block_reader: CMD17 single-block read sequencer on the SPI engine.
// Checks R1 and the start token, then streams 512 bytes plus the CRC.
module sd_block_reader #(
  parameter int TOKEN_WAIT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sd_ready,
  input  logic        card_sdhc,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_busy,
  output logic        rd_done,
  output logic [2:0]  rd_err,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        data_last,
  output logic [15:0] crc_out,
  output logic [47:0] spi_cmd_data,
  output logic        spi_cmd,
  output logic [9:0]  spi_bytes_expected,
  input  logic        spi_busy,
  input  logic        spi_error,
  input  logic [7:0]  spi_response,
  input  logic        spi_avail
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, R1, TOKEN, DATA, CRC, DRAIN, DONE
  } state_t;

  localparam logic [9:0] WAIT_N = 10'(TOKEN_WAIT);

  state_t      state, state_nxt;
  logic [9:0]  cnt, cnt_nxt;
  logic [2:0]  err_nxt;
  logic        busy_nxt, done_nxt;
  logic        valid_nxt, last_nxt;
  logic [7:0]  dout_nxt;
  logic [15:0] crc_nxt;
  logic [47:0] frame_nxt;
  logic [31:0] arg;
  logic        take;
  logic        in_xfer;

  assign spi_bytes_expected = 10'(TOKEN_WAIT + 515);
  assign spi_cmd = (state == ISSUE) && !spi_busy;
  assign arg = card_sdhc ? rd_addr : {rd_addr[22:0], 9'b0};
  assign take = spi_avail && spi_busy && !spi_error;
  assign in_xfer = (state == R1) || (state == TOKEN) ||
                   (state == DATA) || (state == CRC);

  // Next-state and datapath updates; abort conditions override byte handling.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = rd_err;
    busy_nxt  = rd_busy;
    done_nxt  = 1'b0;
    valid_nxt = 1'b0;
    last_nxt  = 1'b0;
    dout_nxt  = data_out;
    crc_nxt   = crc_out;
    frame_nxt = spi_cmd_data;
    unique case (state)
      IDLE: begin
        if (rd_req) begin
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
          frame_nxt = {8'h51, arg, 8'hFF};
          if (sd_ready) begin
            err_nxt   = 3'd0;
            state_nxt = ISSUE;
          end else begin
            err_nxt   = 3'd6;
            state_nxt = DONE;
          end
        end
      end
      ISSUE: begin
        if (!spi_busy) state_nxt = R1;
      end
      R1: begin
        if (take) begin
          if (spi_response == 8'h00) begin
            state_nxt = TOKEN;
            cnt_nxt   = '0;
          end else begin
            err_nxt   = 3'd1;
            state_nxt = DRAIN;
          end
        end
      end
      TOKEN: begin
        if (take) begin
          if (spi_response == 8'hFE) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
          end else if (spi_response[7:4] == 4'h0) begin
            err_nxt   = 3'd3;
            state_nxt = DRAIN;
          end else begin
            cnt_nxt = cnt + 10'd1;
            if ((cnt + 10'd1) == WAIT_N) begin
              err_nxt   = 3'd2;
              state_nxt = DRAIN;
            end
          end
        end
      end
      DATA: begin
        if (take) begin
          dout_nxt  = spi_response;
          valid_nxt = 1'b1;
          cnt_nxt   = cnt + 10'd1;
          if (cnt == 10'd511) begin
            last_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = CRC;
          end
        end
      end
      CRC: begin
        if (take) begin
          cnt_nxt = cnt + 10'd1;
          if (!cnt[0]) begin
            crc_nxt[15:8] = spi_response;
          end else begin
            crc_nxt[7:0] = spi_response;
            state_nxt    = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (spi_error && rd_err == 3'd0) err_nxt = 3'd4;
        if (!spi_busy) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
    endcase
    if (in_xfer) begin
      if (spi_error) begin
        err_nxt   = 3'd4;
        state_nxt = DRAIN;
      end else if (!spi_busy) begin
        err_nxt   = 3'd5;
        state_nxt = DONE;
      end
    end
    if (state != DONE && state_nxt == DONE) begin
      done_nxt = 1'b1;
      busy_nxt = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_err       <= '0;
      rd_busy      <= 1'b0;
      rd_done      <= 1'b0;
      data_valid   <= 1'b0;
      data_last    <= 1'b0;
      data_out     <= '0;
      crc_out      <= '0;
      spi_cmd_data <= 48'hFFFF_FFFF_FFFF;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rd_err       <= err_nxt;
      rd_busy      <= busy_nxt;
      rd_done      <= done_nxt;
      data_valid   <= valid_nxt;
      data_last    <= last_nxt;
      data_out     <= dout_nxt;
      crc_out      <= crc_nxt;
      spi_cmd_data <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_sd_block_reader.sv
// tb_sd_block_reader: directed tests for sd_block_reader.
// A scripted engine replays byte lists; each task checks its own results.
module tb_sd_block_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sd_ready = 1'b0;
  logic        card_sdhc = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        rd_busy, rd_done;
  logic [2:0]  rd_err;
  logic [7:0]  data_out;
  logic        data_valid, data_last;
  logic [15:0] crc_out;
  logic [47:0] spi_cmd_data;
  logic        spi_cmd;
  logic [9:0]  spi_bytes_expected;
  logic        spi_busy = 1'b0;
  logic        spi_error = 1'b0;
  logic [7:0]  spi_response = '0;
  logic        spi_avail = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int dv_cnt = 0;
  int last_cnt = 0;
  int last_pos = -1;
  int done_cnt = 0;
  int cmd_cnt = 0;
  logic [7:0] got [0:4095];
  logic [7:0] rsp [$];

  always #5 clk = ~clk;

  sd_block_reader #(.TOKEN_WAIT(256)) dut (
    .clk(clk), .rst(rst), .sd_ready(sd_ready), .card_sdhc(card_sdhc),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(rd_busy),
    .rd_done(rd_done), .rd_err(rd_err), .data_out(data_out),
    .data_valid(data_valid), .data_last(data_last), .crc_out(crc_out),
    .spi_cmd_data(spi_cmd_data), .spi_cmd(spi_cmd),
    .spi_bytes_expected(spi_bytes_expected), .spi_busy(spi_busy),
    .spi_error(spi_error), .spi_response(spi_response),
    .spi_avail(spi_avail)
  );

  // Event recorder for strobes.
  always @(negedge clk) begin
    if (data_valid) begin
      got[dv_cnt % 4096] = data_out;
      if (data_last) begin
        last_cnt++;
        last_pos = dv_cnt;
      end
      dv_cnt++;
    end
    if (rd_done) done_cnt++;
    if (spi_cmd) cmd_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

  task automatic req(input logic [31:0] a, input logic sdhc);
    @(posedge clk);
    #1 rd_req = 1'b1;
    rd_addr = a;
    card_sdhc = sdhc;
    @(posedge clk);
    #1 rd_req = 1'b0;
  endtask

  task automatic wait_cmd(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (spi_cmd) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic engine(input bit keep_busy);
    @(posedge clk);
    #1 spi_busy = 1'b1;
    foreach (rsp[i]) begin
      @(posedge clk);
      #1 spi_avail = 1'b1;
      spi_response = rsp[i];
    end
    @(posedge clk);
    #1 spi_avail = 1'b0;
    if (!keep_busy) spi_busy = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rd_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic build_read(input int nff, input logic [15:0] crc);
    rsp = {};
    rsp.push_back(8'h00);
    for (int i = 0; i < nff; i++) rsp.push_back(8'hFF);
    rsp.push_back(8'hFE);
    for (int i = 0; i < 512; i++) rsp.push_back(8'(i));
    rsp.push_back(crc[15:8]);
    rsp.push_back(crc[7:0]);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({rd_busy, rd_done, data_valid, data_last, spi_cmd} !== 5'b0 ||
        rd_err !== 3'd0 || data_out !== 8'd0 || crc_out !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_outs: busy=%b done=%b dv=%b last=%b cmd=%b err=%0d d=%h crc=%h required all 0",
               rd_busy, rd_done, data_valid, data_last, spi_cmd,
               rd_err, data_out, crc_out);
    end
    vectors++;
    if (spi_cmd_data !== 48'hFFFF_FFFF_FFFF ||
        spi_bytes_expected !== 10'd771) begin
      miscompares++;
      $display("FAIL reset_frame: frame=%h bytes=%0d required ffffffffffff/771",
               spi_cmd_data, spi_bytes_expected);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_sdhc_read();
    bit ok;
    int b0, l0, bad;
    b0 = dv_cnt;
    l0 = last_cnt;
    sd_ready = 1'b1;
    build_read(3, 16'hABCD);
    req(32'h10, 1'b1);
    @(negedge clk);
    vectors++;
    if ({rd_busy, spi_cmd} !== 2'b11) begin
      miscompares++;
      $display("FAIL sdhc_accept: busy=%b cmd=%b required 1 1",
               rd_busy, spi_cmd);
    end
    vectors++;
    if (spi_cmd_data !== 48'h51_0000_0010_FF) begin
      miscompares++;
      $display("FAIL sdhc_frame: got %h required 510000_0010ff",
               spi_cmd_data);
    end
    engine(1'b0);
    wait_done(ok);
    vectors++;
    if (!ok || rd_err !== 3'd0 || rd_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sdhc_done: seen=%b err=%0d busy=%b required 1 0 0",
               ok, rd_err, rd_busy);
    end
    vectors++;
    if (dv_cnt - b0 != 512) begin
      miscompares++;
      $display("FAIL sdhc_count: got %0d valid required 512", dv_cnt - b0);
    end
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (got[(b0 + i) % 4096] !== 8'(i)) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL sdhc_data: %0d wrong bytes required 0", bad);
    end
    vectors++;
    if (last_cnt - l0 != 1 || last_pos != b0 + 511) begin
      miscompares++;
      $display("FAIL sdhc_last: pulses=%0d pos=%0d required 1 at %0d",
               last_cnt - l0, last_pos - b0, 511);
    end
    vectors++;
    if (crc_out !== 16'hABCD) begin
      miscompares++;
      $display("FAIL sdhc_crc: got %h required abcd", crc_out);
    end
  endtask

  task automatic test_sdsc_addr();
    bit ok;
    build_read(0, 16'h1234);
    req(32'h3, 1'b0);
    wait_cmd(ok);
    vectors++;
    if (!ok || spi_cmd_data !== 48'h51_0000_0600_FF) begin
      miscompares++;
      $display("FAIL sdsc_frame: cmd=%b frame=%h required 1 510000_0600ff",
               ok, spi_cmd_data);
    end
    if (ok) engine(1'b0);
    wait_done(ok);
    vectors++;
    if (!ok || rd_err !== 3'd0 || crc_out !== 16'h1234) begin
      miscompares++;
      $display("FAIL sdsc_done: seen=%b err=%0d crc=%h required 1 0 1234",
               ok, rd_err, crc_out);
    end
  endtask

  task automatic test_err_run(input string name, input logic [2:0] exp,
                              input int exp_dv);
    bit ok;
    int b0;
    b0 = dv_cnt;
    req(32'h40, 1'b1);
    wait_cmd(ok);
    if (ok) engine(1'b0);
    wait_done(ok);
    vectors++;
    if (!ok || rd_err !== exp) begin
      miscompares++;
      $display("FAIL %s_err: seen=%b err=%0d required 1 %0d",
               name, ok, rd_err, exp);
    end
    vectors++;
    if (dv_cnt - b0 != exp_dv) begin
      miscompares++;
      $display("FAIL %s_valid: got %0d required %0d",
               name, dv_cnt - b0, exp_dv);
    end
  endtask

  task automatic test_r1_error();
    rsp = '{8'h05, 8'hFF, 8'hFE, 8'h11, 8'h22};
    test_err_run("r1", 3'd1, 0);
  endtask

  task automatic test_token_timeout();
    rsp = {};
    rsp.push_back(8'h00);
    for (int i = 0; i < 256; i++) rsp.push_back(8'hFF);
    test_err_run("token_to", 3'd2, 0);
  endtask

  task automatic test_data_token();
    rsp = '{8'h00, 8'hFF, 8'h08, 8'hFE, 8'h33};
    test_err_run("data_tok", 3'd3, 0);
  endtask

  task automatic test_premature();
    rsp = {};
    rsp.push_back(8'h00);
    rsp.push_back(8'hFE);
    for (int i = 0; i < 100; i++) rsp.push_back(8'(i));
    test_err_run("premature", 3'd5, 100);
  endtask

  task automatic test_not_ready();
    int c0;
    c0 = cmd_cnt;
    sd_ready = 1'b0;
    req(32'h55, 1'b1);
    @(negedge clk);
    vectors++;
    if (rd_done !== 1'b1 || rd_err !== 3'd6 || rd_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL not_ready: done=%b err=%0d busy=%b required 1 6 0",
               rd_done, rd_err, rd_busy);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (cmd_cnt != c0) begin
      miscompares++;
      $display("FAIL not_ready_cmd: got %0d cmd pulses required 0",
               cmd_cnt - c0);
    end
    sd_ready = 1'b1;
  endtask

  task automatic test_reset_mid_data();
    bit ok;
    int d0;
    rsp = {};
    rsp.push_back(8'h00);
    rsp.push_back(8'hFE);
    for (int i = 0; i < 20; i++) rsp.push_back(8'(i + 1));
    req(32'h20, 1'b1);
    wait_cmd(ok);
    if (ok) engine(1'b1);
    d0 = done_cnt;
    rst = 1'b1;
    spi_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({rd_busy, rd_done, data_valid, data_last, spi_cmd} !== 5'b0 ||
        rd_err !== 3'd0 || data_out !== 8'd0 || crc_out !== 16'd0 ||
        spi_cmd_data !== 48'hFFFF_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL rst_mid: busy=%b done=%b dv=%b err=%0d d=%h crc=%h frame=%h required reset values",
               rd_busy, rd_done, data_valid, rd_err, data_out,
               crc_out, spi_cmd_data);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (done_cnt != d0 || rd_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_done: done pulses=%0d busy=%b required 0 0",
               done_cnt - d0, rd_busy);
    end
  endtask

  initial begin
    test_reset();
    test_sdhc_read();
    test_sdsc_addr();
    test_r1_error();
    test_token_timeout();
    test_data_token();
    test_premature();
    test_not_ready();
    test_reset_mid_data();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
